sonic_scan_ctrl: RTL and testbench

Round-robin scheduler that shares one measurement datapath among `N_SENSORS` ultrasonic rangefinders. For each sensor in turn it:

- fires that sensor's trigger,
- times the echo pulse in microseconds,
- converts the pulse width to centimetres,
- stores the result in a per-sensor result register.

It sits between the board-level Trig/Echo pins and the consumers of distance, such as LED bar logic and motor-enable logic, which read the stored per-sensor distances.

---
 rtl/sonic_pkg.sv | 29 ++
 rtl/sonic_us_tick.sv | 36 +++
 rtl/sonic_scan_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_sonic_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_pkg.sv
// Shared types and constants for the ultrasonic scan controller.
// Latency: n/a (declarations only).
// Flow control: n/a.
package sonic_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_STORE     = 3'd4,
    S_GAP       = 3'd5
  } state_t;

  // cm = us * 17 / 1024 approximates us / 58 (round-trip sound speed).
  localparam int unsigned CM_MUL   = 17;
  localparam int unsigned CM_SHIFT = 10;

  // Distance reported when no usable echo was seen.
  localparam logic [19:0] DIST_TIMEOUT = 20'hFFFFF;

  // 25-bit product, shifted, truncated to the 20-bit result field.
  function automatic logic [19:0] us_to_cm(input logic [19:0] us);
    logic [24:0] prod;
    prod = {5'd0, us} * 25'(CM_MUL);
    return 20'(prod >> CM_SHIFT);
  endfunction

endpackage

// File: rtl/sonic_us_tick.sv
// Microsecond tick generator: divides clk by US_DIV.
// Latency: tick is high in the US_DIV-th cycle after a clear.
// Flow control: none; synchronous clear restarts the period.
module sonic_us_tick #(
  parameter int US_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (US_DIV > 1) ? $clog2(US_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(US_DIV - 1));

  // Count up, wrap on tick, restart on clear.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  // Divider state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sonic_scan_ctrl.sv
// Round-robin trigger/echo timer for N ultrasonic rangefinders.
// Latency: pin edges seen 2-3 cycles late; result written on the edge after fall detect.
// Flow control: none; results land in per-sensor registers with a one-cycle valid pulse.
module sonic_scan_ctrl
  import sonic_pkg::*;
#(
  parameter int N_SENSORS   = 3,
  parameter int TRIG_CYCLES = 1000,
  parameter int TIMEOUT_US  = 30000,
  parameter int GAP_CYCLES  = 6_000_000,
  parameter int US_DIV      = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [N_SENSORS-1:0]    Echo,
  output logic [N_SENSORS-1:0]    Trig,
  output logic [20*N_SENSORS-1:0] distance,
  output logic [N_SENSORS-1:0]    timed_out,
  output logic                    result_valid,
  output logic [2:0]              result_idx,
  output logic                    busy
);

  state_t                    state_q, state_d;
  logic [2:0]                idx_q, idx_d;
  logic [31:0]               cyc_q, cyc_d;
  logic [19:0]               us_q, us_d;
  logic [N_SENSORS-1:0]      trig_q, trig_d;
  logic [20*N_SENSORS-1:0]   dist_q, dist_d;
  logic [N_SENSORS-1:0]      to_q, to_d;
  logic                      rv_q, rv_d;
  logic [2:0]                ridx_q, ridx_d;

  logic [N_SENSORS-1:0]      sync1_q, sync2_q, prev_q;
  logic                      echo_now, echo_old, echo_rise, echo_fall;
  logic                      tick, tick_clr;
  logic                      wr_store, wr_timeout;

  // Two-flop synchroniser plus one history stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= Echo;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Only the selected sensor's synchronised echo is looked at.
  always_comb begin
    echo_now = 1'b0;
    echo_old = 1'b0;
    for (int k = 0; k < N_SENSORS; k++) begin
      if (idx_q == 3'(k)) begin
        echo_now = sync2_q[k];
        echo_old = prev_q[k];
      end
    end
  end

  assign echo_rise = echo_now & ~echo_old;
  assign echo_fall = ~echo_now & echo_old;

  // Divider restarts during the trigger and on the echo rise so width is measured from the rise.
  assign tick_clr = (state_q == S_TRIG) || ((state_q == S_WAIT_RISE) && echo_rise);

  sonic_us_tick #(.US_DIV(US_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  // Next-state, counters and result register updates.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cyc_d      = cyc_q;
    us_d       = us_q;
    trig_d     = '0;
    dist_d     = dist_q;
    to_d       = to_q;
    rv_d       = 1'b0;
    ridx_d     = ridx_q;
    wr_store   = 1'b0;
    wr_timeout = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_TRIG;
          cyc_d   = '0;
        end
      end
      S_TRIG: begin
        for (int k = 0; k < N_SENSORS; k++) begin
          if (idx_q == 3'(k)) trig_d[k] = 1'b1;
        end
        us_d  = '0;
        cyc_d = cyc_q + 32'd1;
        if (cyc_q == 32'(TRIG_CYCLES - 1)) begin
          state_d = S_WAIT_RISE;
        end
      end
      S_WAIT_RISE: begin
        // A level already high here never produces a rise; only a fresh edge counts.
        if (echo_rise) begin
          state_d = S_MEASURE;
          us_d    = '0;
        end else if (us_q >= 20'(TIMEOUT_US)) begin
          wr_timeout = 1'b1;
        end else if (tick) begin
          us_d = us_q + 20'd1;
        end
      end
      S_MEASURE: begin
        if (tick) us_d = us_q + 20'd1;
        // Fall beats timeout when both happen together.
        if (echo_fall) begin
          wr_store = 1'b1;
        end else if (us_q >= 20'(TIMEOUT_US)) begin
          wr_timeout = 1'b1;
        end
      end
      S_STORE: begin
        state_d = S_GAP;
        cyc_d   = '0;
      end
      S_GAP: begin
        cyc_d = cyc_q + 32'd1;
        if (cyc_q == 32'(GAP_CYCLES - 1)) begin
          idx_d   = (idx_q == 3'(N_SENSORS - 1)) ? 3'd0 : idx_q + 3'd1;
          state_d = enable ? S_TRIG : S_IDLE;
          cyc_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Result write: real distance on a fall, saturated marker on timeout.
    if (wr_store || wr_timeout) begin
      rv_d    = 1'b1;
      ridx_d  = idx_q;
      state_d = wr_store ? S_STORE : S_GAP;
      cyc_d   = '0;
      for (int k = 0; k < N_SENSORS; k++) begin
        if (idx_q == 3'(k)) begin
          dist_d[20*k +: 20] = wr_store ? us_to_cm(us_d) : DIST_TIMEOUT;
          to_d[k]            = wr_timeout;
        end
      end
    end
  end

  // Control and result registers; reset drops Trig asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cyc_q   <= '0;
      us_q    <= '0;
      trig_q  <= '0;
      dist_q  <= '0;
      to_q    <= '0;
      rv_q    <= 1'b0;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      us_q    <= us_d;
      trig_q  <= trig_d;
      dist_q  <= dist_d;
      to_q    <= to_d;
      rv_q    <= rv_d;
      ridx_q  <= ridx_d;
    end
  end

  assign Trig         = trig_q;
  assign distance     = dist_q;
  assign timed_out    = to_q;
  assign result_valid = rv_q;
  assign result_idx   = ridx_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_sonic_scan_ctrl.sv
// Directed bench for sonic_scan_ctrl with an echo pin model and event monitor.
// Latency: checks are taken at negedges, away from the active edge.
// Flow control: n/a.
module tb_sonic_scan_ctrl;

  localparam int N     = 3;
  localparam int TRIGC = 1000;
  localparam int TMO   = 6000;
  localparam int GAPC  = 2000;
  localparam int DIV   = 2;
  localparam int DLY   = 50;

  logic           clk;
  logic           rst;
  logic           enable;
  logic [N-1:0]   Echo;
  logic [N-1:0]   Trig;
  logic [20*N-1:0] distance;
  logic [N-1:0]   timed_out;
  logic           result_valid;
  logic [2:0]     result_idx;
  logic           busy;

  sonic_scan_ctrl #(
    .N_SENSORS   (N),
    .TRIG_CYCLES (TRIGC),
    .TIMEOUT_US  (TMO),
    .GAP_CYCLES  (GAPC),
    .US_DIV      (DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .Echo         (Echo),
    .Trig         (Trig),
    .distance     (distance),
    .timed_out    (timed_out),
    .result_valid (result_valid),
    .result_idx   (result_idx),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Echo pin model: pulse of w[k] cycles starting DLY cycles after Trig[k] falls.
  int   w[N]   = '{default: 0};
  bit   pre[N] = '{default: 0};
  bit   xtalk  = 1'b0;
  int   t[N]   = '{default: -1};
  logic [N-1:0] mdl_tprev = '0;

  initial begin
    Echo = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (mdl_tprev[k] && !Trig[k]) t[k] = 0;
        else if (t[k] >= 0) t[k]++;
      end
      mdl_tprev = Trig;
      for (int k = 0; k < N; k++) begin
        Echo[k] = ((t[k] >= DLY) && (t[k] < DLY + w[k])) ||
                  (pre[k] && (Trig[k] || (t[k] >= 0 && t[k] < 20)));
      end
      if (xtalk && t[0] >= 10 && t[0] < 30) Echo[2] = 1'b1;
    end
  end

  // Monitor: trigger order/length/gap and captured results.
  int   cyc = 0;
  int   trig_order[$];
  int   res_idx[$];
  logic [19:0] res_dist[$];
  logic res_to[$];
  int   onehot_bad = 0, len_bad = 0, rv_long = 0;
  int   min_gap = 1 << 30, last_fall = -1, rise_cyc = 0;
  logic [N-1:0]   mon_tprev = '0;
  logic           rv_prev = 1'b0;
  logic [20*N-1:0] dsh;
  logic [N-1:0]   tsh;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if ($countones(Trig) > 1) onehot_bad++;
      for (int k = 0; k < N; k++) begin
        if (Trig[k] && !mon_tprev[k]) begin
          trig_order.push_back(k);
          rise_cyc = cyc;
          if (last_fall >= 0 && (cyc - last_fall) < min_gap) min_gap = cyc - last_fall;
        end
        if (!Trig[k] && mon_tprev[k]) begin
          last_fall = cyc;
          if (cyc - rise_cyc != TRIGC) len_bad++;
        end
      end
      mon_tprev = Trig;
      if (result_valid) begin
        dsh = distance >> (20 * int'(result_idx));
        tsh = timed_out >> result_idx;
        res_idx.push_back(int'(result_idx));
        res_dist.push_back(dsh[19:0]);
        res_to.push_back(tsh[0]);
        if (rv_prev) rv_long++;
      end
      rv_prev = result_valid;
    end
  end

  task automatic wait_res(input int n, input int budget, input string tag);
    int g;
    g = 0;
    while (res_idx.size() < n && g < budget) begin
      @(negedge clk);
      g++;
    end
    chk(tag, 64'(res_idx.size() >= n), 64'd1);
  endtask

  task automatic chk_res(input int i, input int eidx, input logic [19:0] ed, input logic eto);
    if (res_idx.size() > i) begin
      chk($sformatf("res%0d_idx", i), 64'(res_idx[i]), 64'(eidx));
      chk($sformatf("res%0d_dist", i), 64'(res_dist[i]), 64'(ed));
      chk($sformatf("res%0d_to", i), 64'(res_to[i]), 64'(eto));
    end else begin
      chk($sformatf("res%0d_present", i), 64'd0, 64'd1);
    end
  endtask

  int exp_ord[8] = '{0, 1, 2, 0, 1, 2, 0, 1};

  initial begin
    int g;
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trig", 64'(Trig), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dist", 64'(distance), 64'd0);
    chk("rst_to", 64'(timed_out), 64'd0);
    chk("rst_rv", 64'(result_valid), 64'd0);
    chk("rst_ridx", 64'(result_idx), 64'd0);
    rst = 1'b0;

    // Round 1: 1160us on s0 with crosstalk on s2, no echo on s1, 5800us on s2.
    w[0] = 2 * 1160 + 1; w[1] = 0; w[2] = 2 * 5800 + 1;
    xtalk  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("busy_run", 64'(busy), 64'd1);
    wait_res(1, 8000, "wait_r1");
    chk_res(0, 0, 20'd19, 1'b0);
    chk("xtalk_s2_untouched", 64'(distance[59:40]), 64'd0);
    wait_res(2, 20000, "wait_r2");
    chk_res(1, 1, 20'hFFFFF, 1'b1);
    chk("to_vec_r1", 64'(timed_out), 64'b010);
    wait_res(3, 20000, "wait_r3");
    chk_res(2, 2, 20'd96, 1'b0);

    // Round 2: 580/2900us, s2 echo already high when its wait starts.
    xtalk = 1'b0;
    w[0] = 2 * 580 + 1; w[1] = 2 * 2900 + 1; w[2] = 2 * 200 + 1;
    pre[2] = 1'b1;
    wait_res(6, 30000, "wait_r6");
    chk_res(3, 0, 20'd9, 1'b0);
    chk_res(4, 1, 20'd48, 1'b0);
    chk_res(5, 2, 20'd3, 1'b0);
    chk("to_vec_r2", 64'(timed_out), 64'd0);
    chk("dist_vec_r2", 64'(distance), 64'({20'd3, 20'd48, 20'd9}));

    // Round 3: drop enable while s0 is measuring.
    pre[2] = 1'b0;
    w[0] = 2 * 1160 + 1; w[1] = 0; w[2] = 0;
    g = 0;
    while (!Echo[0] && g < 10000) begin
      @(negedge clk);
      g++;
    end
    chk("echo0_seen", 64'(Echo[0]), 64'd1);
    repeat (100) @(negedge clk);
    enable = 1'b0;
    wait_res(7, 5000, "wait_r7");
    chk_res(6, 0, 20'd19, 1'b0);
    repeat (2200) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    repeat (800) @(negedge clk);
    chk("idle_no_trig", 64'(trig_order.size()), 64'd7);

    // Resume: the next trigger must be sensor 1.
    enable = 1'b1;
    g = 0;
    while (trig_order.size() < 8 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("n_trig", 64'(trig_order.size()), 64'd8);
    if (trig_order.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("trig_ord%0d", i), 64'(trig_order[i]), 64'(exp_ord[i]));
      end
    end
    chk("trig_len", 64'(len_bad), 64'd0);
    chk("trig_onehot", 64'(onehot_bad), 64'd0);
    chk("trig_gap_ok", 64'(min_gap >= GAPC), 64'd1);
    chk("rv_one_cycle", 64'(rv_long), 64'd0);
    chk("n_results", 64'(res_idx.size()), 64'd7);

    // Asynchronous reset in the middle of s1's trigger.
    repeat (100) @(negedge clk);
    chk("pre_rst_trig", 64'(Trig), 64'b010);
    #1 rst = 1'b1;
    #1;
    chk("arst_trig", 64'(Trig), 64'd0);
    chk("arst_dist", 64'(distance), 64'd0);
    chk("arst_to", 64'(timed_out), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_rv", 64'(result_valid), 64'd0);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    rst    = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
